spi_msg_router: RTL

- Sits directly downstream of the SPI stack's send/recv interface.
- Decodes the destination field in each inbound SPI message and forwards the payload to one of num_ports downstream components.
- Round-robin arbitrates the components' responses, tags each with its source port, and returns it to the SPI stack.
- Each direction has a one-entry pipeline buffer, so both the request and the response path are fully registered.

---
 rtl/spi_msg_router.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_msg_router.sv
// spi_msg_router: routes SPI-side requests to one of num_ports downstream
// components by the destination tag in the message MSBs. Responses from the
// components go through a round-robin arbiter, are tagged with their source
// port, and are returned to the SPI stack. Each direction is buffered by a
// single registered entry that can be drained and refilled in the same cycle.

module spi_msg_router #(
    parameter int  nbits      = 32,
    parameter int  addr_nbits = 2,
    localparam int num_ports  = 2**addr_nbits,
    localparam int pw         = nbits - addr_nbits
) (
    input  logic                    clk,
    input  logic                    reset,

    // Request path: SPI stack -> router -> downstream ports
    input  logic                    req_recv_val,
    input  logic [nbits-1:0]        req_recv_msg,
    output logic                    req_recv_rdy,

    // Response path: router -> SPI stack
    output logic                    resp_send_val,
    output logic [nbits-1:0]        resp_send_msg,
    input  logic                    resp_send_rdy,

    // Downstream request interface
    output logic [num_ports-1:0]    dn_req_val,
    output logic [num_ports*pw-1:0] dn_req_msg,
    input  logic [num_ports-1:0]    dn_req_rdy,

    // Downstream response interface
    input  logic [num_ports-1:0]    dn_resp_val,
    input  logic [num_ports*pw-1:0] dn_resp_msg,
    output logic [num_ports-1:0]    dn_resp_rdy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  req_full_q,  req_full_d;
    logic [addr_nbits-1:0] req_dest_q,  req_dest_d;
    logic [pw-1:0]         req_pay_q,   req_pay_d;

    logic                  resp_full_q, resp_full_d;
    logic [addr_nbits-1:0] resp_src_q,  resp_src_d;
    logic [pw-1:0]         resp_pay_q,  resp_pay_d;

    logic [addr_nbits-1:0] rr_ptr_q,    rr_ptr_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  req_fire_s;
    logic                  req_accept_s;
    logic                  resp_send_fire_s;
    logic                  resp_space_s;
    logic                  resp_load_s;
    logic [num_ports-1:0]  grant_s;
    logic [addr_nbits-1:0] grant_idx_s;
    logic                  grant_any_s;
    logic [addr_nbits-1:0] arb_cand_s;
    logic [pw-1:0]         grant_pay_s;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------

    // Request handshake terms; a draining buffer may accept in the same cycle
    always_comb begin
        req_fire_s   = req_full_q && dn_req_rdy[req_dest_q];
        req_recv_rdy = !req_full_q || req_fire_s;
        req_accept_s = req_recv_val && req_recv_rdy;
    end

    // Decode the buffered destination into a per-port valid; payload on all slices
    always_comb begin
        dn_req_val = '0;
        for (int i = 0; i < num_ports; i++) begin
            if (req_full_q && (req_dest_q == addr_nbits'(i))) begin
                dn_req_val[i] = 1'b1;
            end else begin
                dn_req_val[i] = 1'b0;
            end
        end
        dn_req_msg = {num_ports{req_pay_q}};
    end

    // Request buffer next state: load on accept, otherwise empty on fire
    always_comb begin
        req_full_d = req_full_q;
        req_dest_d = req_dest_q;
        req_pay_d  = req_pay_q;
        if (req_accept_s) begin
            req_full_d = 1'b1;
            req_dest_d = req_recv_msg[nbits-1 -: addr_nbits];
            req_pay_d  = req_recv_msg[pw-1:0];
        end else if (req_fire_s) begin
            req_full_d = 1'b0;
        end else begin
            req_full_d = req_full_q;
        end
    end

    // ------------------------------------------------------------------
    // Response arbitration
    // ------------------------------------------------------------------

    // Round-robin search starting at rr_ptr; the first valid port wins
    always_comb begin
        grant_s     = '0;
        grant_idx_s = rr_ptr_q;
        grant_any_s = 1'b0;
        arb_cand_s  = rr_ptr_q;
        for (int k = 0; k < num_ports; k++) begin
            // pointer arithmetic wraps naturally because num_ports is a power of two
            arb_cand_s = rr_ptr_q + addr_nbits'(k);
            if (!grant_any_s && dn_resp_val[arb_cand_s]) begin
                grant_any_s          = 1'b1;
                grant_idx_s          = arb_cand_s;
                grant_s[arb_cand_s]  = 1'b1;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // AND-OR select of the granted port's payload
    always_comb begin
        grant_pay_s = '0;
        for (int i = 0; i < num_ports; i++) begin
            if (grant_s[i]) begin
                grant_pay_s = grant_pay_s | dn_resp_msg[i*pw +: pw];
            end else begin
                grant_pay_s = grant_pay_s;
            end
        end
    end

    // Grant is only offered when the response buffer has room this cycle
    always_comb begin
        resp_send_fire_s = resp_full_q && resp_send_rdy;
        resp_space_s     = !resp_full_q || resp_send_fire_s;
        if (resp_space_s) begin
            dn_resp_rdy = grant_s;
        end else begin
            dn_resp_rdy = '0;
        end
        resp_load_s = resp_space_s && grant_any_s;
    end

    // Response buffer and pointer next state: a load wins over a drain
    always_comb begin
        resp_full_d = resp_full_q;
        resp_src_d  = resp_src_q;
        resp_pay_d  = resp_pay_q;
        rr_ptr_d    = rr_ptr_q;
        if (resp_load_s) begin
            resp_full_d = 1'b1;
            resp_src_d  = grant_idx_s;
            resp_pay_d  = grant_pay_s;
            rr_ptr_d    = grant_idx_s + {{(addr_nbits-1){1'b0}}, 1'b1};
        end else if (resp_send_fire_s) begin
            resp_full_d = 1'b0;
        end else begin
            resp_full_d = resp_full_q;
        end
    end

    // Response outputs come straight from the buffer registers
    always_comb begin
        resp_send_val = resp_full_q;
        resp_send_msg = {resp_src_q, resp_pay_q};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control state: occupancy flags and arbiter pointer, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            req_full_q  <= 1'b0;
            resp_full_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            req_full_q  <= req_full_d;
            resp_full_q <= resp_full_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Data registers: contents are qualified by the full flags, so no reset
    always_ff @(posedge clk) begin
        req_dest_q <= req_dest_d;
        req_pay_q  <= req_pay_d;
        resp_src_q <= resp_src_d;
        resp_pay_q <= resp_pay_d;
    end

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
    spi_msg_router_chk #(
        .nbits     (nbits),
        .num_ports (num_ports)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .dn_req_val    (dn_req_val),
        .dn_req_rdy    (dn_req_rdy),
        .dn_resp_val   (dn_resp_val),
        .dn_resp_rdy   (dn_resp_rdy),
        .resp_send_val (resp_send_val),
        .resp_send_rdy (resp_send_rdy),
        .resp_send_msg (resp_send_msg)
    );

endmodule

// spi_msg_router_chk: handshake invariants of the router's outputs
module spi_msg_router_chk #(
    parameter int nbits     = 32,
    parameter int num_ports = 4
) (
    input logic                 clk,
    input logic                 reset,
    input logic [num_ports-1:0] dn_req_val,
    input logic [num_ports-1:0] dn_req_rdy,
    input logic [num_ports-1:0] dn_resp_val,
    input logic [num_ports-1:0] dn_resp_rdy,
    input logic                 resp_send_val,
    input logic                 resp_send_rdy,
    input logic [nbits-1:0]     resp_send_msg
);

    a_req_val_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(dn_req_val));

    a_resp_rdy_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(dn_resp_rdy));

    a_resp_rdy_needs_val: assert property (@(posedge clk) disable iff (reset)
        ((dn_resp_rdy & ~dn_resp_val) == '0));

    a_req_hold: assert property (@(posedge clk) disable iff (reset)
        ((|dn_req_val) && ((dn_req_val & dn_req_rdy) == '0)) |=> $stable(dn_req_val));

    a_resp_hold: assert property (@(posedge clk) disable iff (reset)
        (resp_send_val && !resp_send_rdy) |=> (resp_send_val && $stable(resp_send_msg)));

endmodule
